// File: rtl/cache_fill_fsm.sv
// Cache block fill controller.
// On a miss it captures the block-aligned base address and issues one word read
// per cycle for the whole block. It writes each returned word into the data
// array and pulses the tag write together with the last word. fsm_busy stalls
// the CPU for the whole fill.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no fill in progress; the next miss is accepted on the next edge
// ST_WAIT | fill in progress; requests go out, returned words are written

module cache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int AWIDTH      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [AWIDTH-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data,
   output logic              fsm_busy,
   output logic              memory_read,
   output logic [AWIDTH-1:0] memory_address,
   output logic              write_data_array,
   output logic [AWIDTH-1:0] fill_address,
   output logic [15:0]       fill_data,
   output logic              write_tag_array
);

   localparam int IDXW = $clog2(BLOCK_WORDS);
   localparam int CNTW = IDXW + 1;
   localparam logic [CNTW-1:0]   CNT_FULL   = CNTW'(BLOCK_WORDS);
   localparam logic [CNTW-1:0]   CNT_LAST   = CNTW'(BLOCK_WORDS - 1);
   localparam logic [CNTW-1:0]   CNT_ONE    = CNTW'(1);
   // A block spans BLOCK_WORDS 16-bit words, i.e. 2*BLOCK_WORDS bytes.
   localparam logic [AWIDTH-1:0] BLOCK_MASK = AWIDTH'((2 * BLOCK_WORDS) - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t            state_q,   state_d;
   logic [AWIDTH-1:0] base_q,    base_d;
   logic [CNTW-1:0]   req_cnt_q, req_cnt_d;
   logic [CNTW-1:0]   rcv_cnt_q, rcv_cnt_d;

   logic              in_wait;
   logic              req_active;
   logic              word_accept;
   logic              last_word;
   logic [AWIDTH-1:0] req_offset;
   logic [AWIDTH-1:0] rcv_offset;

   // Decode the current request/receive situation and the byte offsets.
   // Only the index bits of the counters form the offset, so the address
   // never leaves the block even when a counter reaches BLOCK_WORDS.
   always_comb begin
      in_wait     = (state_q == ST_WAIT);
      req_active  = in_wait && (req_cnt_q < CNT_FULL);
      word_accept = in_wait && memory_data_valid;
      last_word   = word_accept && (rcv_cnt_q == CNT_LAST);
      req_offset  = AWIDTH'({req_cnt_q[IDXW-1:0], 1'b0});
      rcv_offset  = AWIDTH'({rcv_cnt_q[IDXW-1:0], 1'b0});
   end

   // Next-state logic: accept a miss in IDLE; in WAIT issue requests,
   // count returned words and return to IDLE on the last word.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      req_cnt_d = req_cnt_q;
      rcv_cnt_d = rcv_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (miss_detected) begin
               base_d    = miss_address & ~BLOCK_MASK;
               req_cnt_d = '0;
               rcv_cnt_d = '0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (req_active) begin
               req_cnt_d = req_cnt_q + CNT_ONE;
            end
            if (word_accept) begin
               rcv_cnt_d = rcv_cnt_q + CNT_ONE;
            end
            if (last_word) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs. fsm_busy comes straight from the state flop, so a miss has no
   // combinational path to the stall signal.
   always_comb begin
      fsm_busy         = in_wait;
      memory_read      = req_active;
      memory_address   = req_active ? (base_q + req_offset) : '0;
      write_data_array = word_accept;
      fill_address     = base_q + rcv_offset;
      fill_data        = memory_data;
      write_tag_array  = last_word;
   end

   // State and datapath registers with synchronous reset; reset aborts any fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         req_cnt_q <= '0;
         rcv_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         req_cnt_q <= req_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: directed fill scenarios plus a randomized phase.
// The model tracks each fill by its start cycle and its count of written words.
// It is checked against the DUT every cycle.

module tb_cache_fill_fsm;

   localparam int BW = 8;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          miss_detected = 1'b0;
   logic [AW-1:0] miss_address = '0;
   logic          memory_data_valid = 1'b0;
   logic [15:0]   memory_data = '0;
   logic          fsm_busy;
   logic          memory_read;
   logic [AW-1:0] memory_address;
   logic          write_data_array;
   logic [AW-1:0] fill_address;
   logic [15:0]   fill_data;
   logic          write_tag_array;

   cache_fill_fsm #(.BLOCK_WORDS(BW), .AWIDTH(AW)) dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .memory_read       (memory_read),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .fill_address      (fill_address),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Memory: a request seen in cycle c returns data in cycle c+lat+1.
   int            lat = 4;
   logic          pend_v [32];
   logic [AW-1:0] pend_a [32];
   logic [15:0]   salt = 16'h5A3C;

   // Stimulus modes.
   int stray_mode = 0;
   bit miss_when_busy = 1'b0;

   // Model of the block.
   bit            m_busy = 1'b0;
   logic [AW-1:0] m_base = '0;
   int            m_start = 0;
   int            m_wr = 0;
   bit            m_fresh = 1'b1;

   // Statistics gathered from the DUT outputs.
   int            st_busy, st_reads, st_writes, st_tags, st_tag_at;
   int            st_nrise, st_nfall;
   int            st_rise [4];
   int            st_fall [4];
   logic [AW-1:0] st_addr [64];
   bit            prev_busy = 1'b0;

   logic [AW-1:0] exp_addr;
   bit            exp_rd, exp_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      st_busy = 0; st_reads = 0; st_writes = 0; st_tags = 0; st_tag_at = -1;
      st_nrise = 0; st_nfall = 0;
      for (int i = 0; i < 4; i++) begin
         st_rise[i] = -1;
         st_fall[i] = -1;
      end
      for (int i = 0; i < 64; i++) st_addr[i] = '0;
   endtask

   // Model update for the edge that ends the current cycle (inputs still held).
   task automatic model_edge();
      if (rst) begin
         m_busy  = 1'b0;
         m_base  = '0;
         m_wr    = 0;
         m_fresh = 1'b1;
         for (int i = 0; i < 32; i++) pend_v[i] = 1'b0;
      end else if (!m_busy) begin
         if (miss_detected) begin
            m_busy  = 1'b1;
            m_base  = miss_address & ~AW'(2 * BW - 1);
            m_start = cyc + 1;
            m_wr    = 0;
            m_fresh = 1'b0;
         end
      end else if (memory_data_valid) begin
         m_wr++;
         if (m_wr == BW) m_busy = 1'b0;
      end
   endtask

   // Per-cycle comparison of all outputs, plus memory response scheduling.
   task automatic compare();
      exp_rd = m_busy && ((cyc - m_start) < BW);
      exp_wr = m_busy && memory_data_valid;
      chk("fsm_busy", fsm_busy, m_busy);
      chk("memory_read", memory_read, exp_rd);
      if (exp_rd) begin
         exp_addr = m_base + AW'(2 * (cyc - m_start));
         chk("memory_address", memory_address, exp_addr);
      end
      chk("write_data_array", write_data_array, exp_wr);
      if (exp_wr) begin
         exp_addr = m_base + AW'(2 * m_wr);
         chk("fill_address", fill_address, exp_addr);
         chk("fill_data", fill_data, memory_data);
      end
      chk("write_tag_array", write_tag_array, exp_wr && (m_wr == BW - 1));
      if (m_fresh) begin
         chk("reset_memory_address", memory_address, 0);
         chk("reset_fill_address", fill_address, 0);
      end
      if (memory_read) begin
         pend_v[(cyc + lat + 1) % 32] = 1'b1;
         pend_a[(cyc + lat + 1) % 32] = memory_address;
         if (st_reads < 64) st_addr[st_reads] = memory_address;
         st_reads++;
      end
      if (fsm_busy) st_busy++;
      if (write_data_array) st_writes++;
      if (write_tag_array) begin
         st_tags++;
         st_tag_at = st_writes;
      end
      if (fsm_busy && !prev_busy && st_nrise < 4) begin
         st_rise[st_nrise] = cyc;
         st_nrise++;
      end
      if (!fsm_busy && prev_busy && st_nfall < 4) begin
         st_fall[st_nfall] = cyc;
         st_nfall++;
      end
      prev_busy = fsm_busy;
   endtask

   // One clock cycle: model edge, drive this cycle's inputs, compare mid-cycle.
   task automatic tick(input bit r, input bit m, input logic [AW-1:0] a);
      int idx;
      @(posedge clk);
      #1;
      model_edge();
      cyc++;
      rst = r;
      miss_detected = m | (miss_when_busy & m_busy);
      miss_address  = (miss_when_busy && m_busy) ? 16'h4000 : a;
      idx = cyc % 32;
      if (pend_v[idx]) begin
         memory_data_valid = 1'b1;
         memory_data = pend_a[idx] ^ salt;
         pend_v[idx] = 1'b0;
      end else if (!m_busy && (stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 3) == 0))) begin
         memory_data_valid = 1'b1;
         memory_data = (stray_mode == 2) ? 16'hBEEF : 16'($urandom);
      end else begin
         memory_data_valid = 1'b0;
         memory_data = 16'($urandom);
      end
      @(negedge clk);
      compare();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) pend_v[i] = 1'b0;
      clear_stats();

      // Reset, then stray valid words while idle.
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      chk("after_reset_busy", fsm_busy, 0);
      chk("after_reset_tag", write_tag_array, 0);
      stray_mode = 2;
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0);
      chk("stray_write", write_data_array, 0);
      chk("stray_fill_address", fill_address, 0);
      stray_mode = 0;

      // Basic fill at 0x1236 with a miss held at 0x4000 throughout.
      clear_stats();
      lat = 4;
      salt = 16'h1357;
      miss_when_busy = 1'b1;
      tick(1'b0, 1'b1, 16'h1236);
      for (int i = 0; i < 18; i++) tick(1'b0, 1'b0, '0);
      miss_when_busy = 1'b0;
      chk("model_base_1236", m_base, 16'h1230);
      chk("basic_busy_cycles", st_busy, 13);
      chk("basic_reads", st_reads, 8);
      chk("basic_first_addr", st_addr[0], 16'h1230);
      chk("basic_last_addr", st_addr[7], 16'h123E);
      chk("basic_writes", st_writes, 8);
      chk("basic_tags", st_tags, 1);
      chk("basic_tag_on_8th", st_tag_at, 8);

      // Stray valids after a fill, then reset in the middle of a fill.
      stray_mode = 2;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0);
      stray_mode = 0;
      clear_stats();
      tick(1'b0, 1'b1, 16'h5678);
      for (int i = 0; i < 40 && st_writes < 3; i++) tick(1'b0, 1'b0, '0);
      chk("abort_words_seen", st_writes, 3);
      tick(1'b1, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      chk("abort_busy", fsm_busy, 0);
      chk("abort_read", memory_read, 0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);
      chk("abort_no_tag", st_tags, 0);
      clear_stats();
      tick(1'b0, 1'b1, 16'h0010);
      for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, '0);
      chk("refill_first_addr", st_addr[0], 16'h0010);
      chk("refill_last_addr", st_addr[7], 16'h001E);
      chk("refill_busy_cycles", st_busy, 13);
      chk("refill_tags", st_tags, 1);

      // Back-to-back fills at 0xFFF2 then 0x0000.
      clear_stats();
      tick(1'b0, 1'b1, 16'hFFF2);
      for (int i = 0; i < 14; i++) tick(1'b0, 1'b1, 16'h0000);
      for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, '0);
      chk("b2b_first_addr", st_addr[0], 16'hFFF0);
      chk("b2b_first_last_addr", st_addr[7], 16'hFFFE);
      chk("b2b_second_addr", st_addr[8], 16'h0000);
      chk("b2b_reads", st_reads, 16);
      chk("b2b_tags", st_tags, 2);
      chk("b2b_busy_cycles", st_busy, 26);
      chk("b2b_gap", st_rise[1] - st_fall[0], 1);

      // Randomized traffic: latency, misses, stray valids, occasional reset.
      for (int i = 0; i < 3000; i++) begin
         if (!m_busy && $urandom_range(0, 7) == 0) begin
            lat = $urandom_range(1, 6);
            salt = 16'($urandom);
         end
         stray_mode = $urandom_range(0, 1);
         tick($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, AW'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
